cordic_arbiter: RTL and testbench

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_arbiter.sv | 142 ++++++++++++++
 tb/tb_cordic_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one fixed-latency CORDIC pipeline between NREQ requesters.
// Tracks per-requester credit and returns results tagged with the requester id.
module cordic_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 32,
  parameter int unsigned MAX_OUT = 8,
  localparam int unsigned IdW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned CntW   = $clog2(MAX_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_angle,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  output logic [31:0]          cd_angle,
  output logic [15:0]          cd_xin,
  output logic [15:0]          cd_yin,
  input  logic [16:0]          cd_cos,
  input  logic [16:0]          cd_sin,
  output logic                 res_valid,
  output logic [IdW-1:0]       res_id,
  output logic [16:0]          res_cos,
  output logic [16:0]          res_sin,
  output logic                 busy
);

  logic [IdW-1:0]  rr_ptr_q;
  logic [CntW-1:0] outstanding_q [NREQ];
  logic [LATENCY:0] tag_v_q;
  logic [IdW-1:0]  tag_id_q [LATENCY+1];

  logic [NREQ-1:0] eligible;
  logic            grant;
  logic [IdW-1:0]  win;
  logic [IdW-1:0]  next_ptr;
  logic [IdW:0]    sum;
  logic [IdW-1:0]  idx;
  logic [31:0]     sel_angle;
  logic [15:0]     sel_x;
  logic [15:0]     sel_y;
  logic            ret_valid;
  logic [IdW-1:0]  ret_id;

  assign ret_valid = tag_v_q[LATENCY];
  assign ret_id    = tag_id_q[LATENCY];

  // Search NREQ slots starting at rr_ptr; first eligible slot wins.
  always_comb begin
    eligible  = '0;
    req_ready = '0;
    grant     = 1'b0;
    win       = '0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = rst_n & en & req_valid[i] & (outstanding_q[i] < CntW'(MAX_OUT));
    end
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IdW+1)'(k);
      if (sum >= (IdW+1)'(NREQ)) begin
        sum = sum - (IdW+1)'(NREQ);
      end
      idx = sum[IdW-1:0];
      if (!grant && eligible[idx]) begin
        grant = 1'b1;
        win   = idx;
      end
    end
    if (grant) begin
      req_ready[win] = 1'b1;
    end
  end

  always_comb begin
    next_ptr = (win == IdW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  always_comb begin
    sel_angle = '0;
    sel_x     = '0;
    sel_y     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_angle = req_angle[32*i +: 32];
        sel_x     = req_x[16*i +: 16];
        sel_y     = req_y[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      tag_v_q   <= '0;
      cd_angle  <= '0;
      cd_xin    <= '0;
      cd_yin    <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_cos   <= '0;
      res_sin   <= '0;
      for (int k = 0; k <= LATENCY; k++) begin
        tag_id_q[k] <= '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        outstanding_q[i] <= '0;
      end
    end else begin
      if (grant) begin
        rr_ptr_q <= next_ptr;
        cd_angle <= sel_angle;
        cd_xin   <= sel_x;
        cd_yin   <= sel_y;
      end
      tag_v_q     <= {tag_v_q[LATENCY-1:0], grant};
      tag_id_q[0] <= win;
      for (int k = 1; k <= LATENCY; k++) begin
        tag_id_q[k] <= tag_id_q[k-1];
      end
      res_valid <= ret_valid;
      if (ret_valid) begin
        res_id  <= ret_id;
        res_cos <= cd_cos;
        res_sin <= cd_sin;
      end
      // Simultaneous grant and return for the same id cancel out.
      for (int i = 0; i < NREQ; i++) begin
        if ((grant && win == IdW'(i)) && !(ret_valid && ret_id == IdW'(i))) begin
          outstanding_q[i] <= outstanding_q[i] + 1'b1;
        end else if (!(grant && win == IdW'(i)) && (ret_valid && ret_id == IdW'(i))) begin
          outstanding_q[i] <= outstanding_q[i] - 1'b1;
        end
      end
    end
  end

  assign busy = (|tag_v_q) | res_valid;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter: a transaction-level arbiter model predicts grants,
// a stand-in CORDIC pipeline produces results, and a monitor checks each returned result.
module tb_cordic_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 32;
  localparam int MAXO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [127:0] req_angle = '0;
  logic [63:0] req_x = '0;
  logic [63:0] req_y = '0;
  logic [31:0] cd_angle;
  logic [15:0] cd_xin, cd_yin;
  logic [16:0] cd_cos, cd_sin;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [16:0] res_cos, res_sin;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int peak1 = 0;

  typedef struct {
    int          id;
    int          due;
    logic [16:0] c;
    logic [16:0] s;
  } exp_t;

  exp_t sb[$];
  exp_t infl[$];
  int   cnt[NREQ];
  int   ptr = 0;

  cordic_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .MAX_OUT(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_angle(req_angle), .req_x(req_x), .req_y(req_y), .cd_angle(cd_angle),
    .cd_xin(cd_xin), .cd_yin(cd_yin), .cd_cos(cd_cos), .cd_sin(cd_sin),
    .res_valid(res_valid), .res_id(res_id), .res_cos(res_cos), .res_sin(res_sin),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in CORDIC: arbitrary operand mix, LAT edges from capture to output.
  function automatic logic [16:0] f_cos(input logic [31:0] a, input logic [15:0] x);
    return {a[31], x ^ a[15:0]};
  endfunction
  function automatic logic [16:0] f_sin(input logic [31:0] a, input logic [15:0] y);
    return {1'b0, y} + a[31:15];
  endfunction

  logic [16:0] pc [LAT];
  logic [16:0] ps [LAT];
  always @(posedge clk) begin
    pc[0] <= f_cos(cd_angle, cd_xin);
    ps[0] <= f_sin(cd_angle, cd_yin);
    for (int k = 1; k < LAT; k++) begin
      pc[k] <= pc[k-1];
      ps[k] <= ps[k-1];
    end
  end
  assign cd_cos = pc[LAT-1];
  assign cd_sin = ps[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference arbiter: credit counts and round-robin pointer, predicting the coming edge.
  always @(negedge clk) begin
    logic [3:0] er;
    int w;
    int i;
    exp_t e;
    while (infl.size() > 0 && infl[0].due <= cyc) begin
      cnt[infl[0].id]--;
      void'(infl.pop_front());
    end
    for (int q = 0; q < NREQ; q++) check("outstanding", 64'(dut.outstanding_q[q]), 64'(cnt[q]));
    er = '0;
    w = -1;
    if (rst_n && en) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (ptr + k) % NREQ;
        if (w < 0 && req_valid[i] && cnt[i] < MAXO) w = i;
      end
    end
    if (w >= 0) er[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(er));
    if (!rst_n) begin
      sb.delete();
      infl.delete();
      for (int q = 0; q < NREQ; q++) cnt[q] = 0;
      ptr = 0;
    end else if (w >= 0) begin
      e.id  = w;
      e.due = cyc + LAT + 2;
      e.c   = f_cos(req_angle[32*w +: 32], req_x[16*w +: 16]);
      e.s   = f_sin(req_angle[32*w +: 32], req_y[16*w +: 16]);
      sb.push_back(e);
      infl.push_back(e);
      cnt[w]++;
      ptr = (w + 1) % NREQ;
    end
  end

  // Monitor: pops the scoreboard whenever a result appears.
  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      check("missing_result", 64'(0), 64'(1));
      void'(sb.pop_front());
    end
    check("busy", 64'(busy), 64'(sb.size() != 0));
    if (res_valid) begin
      if (sb.size() == 0) begin
        check("spurious_res_valid", 64'(res_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        check("res_due_cycle", 64'(cyc), 64'(e.due));
        check("res_id", 64'(res_id), 64'(e.id));
        check("res_cos", 64'(res_cos), 64'(e.c));
        check("res_sin", 64'(res_sin), 64'(e.s));
      end
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      check("res_valid", 64'(res_valid), 64'(1));
      void'(sb.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_angle[32*i +: 32] = $urandom;
      req_x[16*i +: 16] = 16'($urandom);
      req_y[16*i +: 16] = 16'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      step();
      n++;
    end
    check("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    for (int q = 0; q < NREQ; q++) cnt[q] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_id", 64'(res_id), 64'(0));
    check("rst_res_cos", 64'(res_cos), 64'(0));
    check("rst_res_sin", 64'(res_sin), 64'(0));
    check("rst_cd_angle", 64'(cd_angle), 64'(0));
    check("rst_cd_xy", 64'({cd_xin, cd_yin}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    en = 1'b1;

    // Single operation from requester 2.
    req_valid = 4'b0100;
    req_angle[95:64] = 32'h2000_0000;
    req_x[47:32] = 16'h4DBA;
    req_y[47:32] = 16'h0000;
    step();
    req_valid = '0;
    drain();

    // All requesters valid continuously.
    req_valid = 4'hF;
    repeat (40) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    drain();

    // Requester 1 alone: credit limit and one grant per returned result.
    peak1 = 0;
    req_valid = 4'b0010;
    repeat (60) begin
      rand_ops();
      step();
      if (int'(dut.outstanding_q[1]) > peak1) peak1 = int'(dut.outstanding_q[1]);
    end
    check("peak_outstanding1", 64'(peak1), 64'(MAXO));
    req_valid = '0;
    drain();

    // Reset with five operations in flight.
    req_valid = 4'b0001;
    repeat (5) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("busy_after_reset", 64'(busy), 64'(0));
    req_valid = 4'b1100;
    repeat (3) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    drain();

    // Enable dropped with three operations in flight.
    req_valid = 4'hF;
    repeat (3) begin
      rand_ops();
      step();
    end
    en = 1'b0;
    repeat (45) step();
    en = 1'b1;
    req_valid = '0;
    drain();

    // Random traffic.
    repeat (400) begin
      rand_ops();
      req_valid = 4'($urandom);
      en = ($urandom_range(0, 9) != 0);
      step();
    end
    req_valid = '0;
    en = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
